// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
// lz_mask flags digits that belong to the run of leading zeros (digit 0 is never flagged).
package ssd_pkg;

   localparam int MAX_DIGITS      = 8;
   localparam int DEF_REFRESH_DIV = 50000;
   localparam int DEF_GUARD       = 2;

   function automatic logic [MAX_DIGITS-1:0] lz_mask(
      input logic [4*MAX_DIGITS-1:0] disp,
      input int                      n_digits
   );
      logic [MAX_DIGITS-1:0] lz;
      logic                  zero_above;
      lz         = {MAX_DIGITS{1'b0}};
      zero_above = 1'b1;
      for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
         if (i < n_digits) begin
            zero_above = zero_above & (disp[4*i +: 4] == 4'h0);
            lz[i]      = (i > 0) & zero_above;
         end else begin
            lz[i] = 1'b0;
         end
      end
      return lz;
   endfunction

endpackage

// File: rtl/ssd_refresh_tick.sv
// Slot timer: counts 0..REFRESH_DIV-1 and flags the last cycle of each digit slot.
// guard_done looks one cycle ahead so the registered enables light exactly when div_cnt reaches GUARD.
module ssd_refresh_tick #(
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 2
) (
   input  logic clk,
   input  logic rst,
   output logic tick,
   output logic guard_done
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_W  = CNT_W'(GUARD);

   logic [CNT_W-1:0] div_cnt;
   logic [CNT_W-1:0] cnt_next;

   // Next count and the look-ahead guard flag
   always_comb begin
      tick       = (div_cnt == LAST_CNT);
      cnt_next   = tick ? {CNT_W{1'b0}} : (div_cnt + CNT_W'(1));
      guard_done = (cnt_next >= GUARD_W);
   end

   // Slot counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= {CNT_W{1'b0}};
      end else begin
         div_cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scanner feeding hex2ssd.
// Double-buffered value (shadow -> disp at frame boundary), blanking and guard-interval enables.
module ssd_scan_ctrl
   import ssd_pkg::*;
#(
   parameter int N_DIGITS      = 4,
   parameter int REFRESH_DIV   = DEF_REFRESH_DIV,
   parameter int GUARD         = DEF_GUARD,
   parameter int AN_ACTIVE_LOW = 1,
   parameter int LZ_BLANK      = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   blank_mask,
   output logic [3:0]            hex,
   output logic [N_DIGITS-1:0]   dig_en,
   output logic                  pending,
   output logic                  frame_done
);

   localparam int IDX_W = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] EN_OFF   = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}}
                                                                    : {N_DIGITS{1'b0}};

   logic                    tick;
   logic                    guard_done;
   logic                    boundary;
   logic [IDX_W-1:0]        idx;
   logic [IDX_W-1:0]        idx_next;
   logic [4*N_DIGITS-1:0]   shadow;
   logic [4*N_DIGITS-1:0]   shadow_next;
   logic [4*N_DIGITS-1:0]   disp;
   logic [4*N_DIGITS-1:0]   disp_next;
   logic                    pending_next;
   logic [4*MAX_DIGITS-1:0] disp_ext;
   logic [MAX_DIGITS-1:0]   lz_full;
   logic [N_DIGITS-1:0]     lz_dark;
   logic [N_DIGITS-1:0]     lit;
   logic [N_DIGITS-1:0]     en_hi;
   logic [N_DIGITS-1:0]     dig_en_next;
   logic [3:0]              hex_next;
   logic                    sel;

   ssd_refresh_tick #(
      .REFRESH_DIV (REFRESH_DIV),
      .GUARD       (GUARD)
   ) u_tick (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .guard_done (guard_done)
   );

   // Next-state logic; outputs are computed from the post-edge idx/disp so they register in step
   always_comb begin
      boundary     = tick && (idx == LAST_IDX);
      idx_next     = tick ? (boundary ? {IDX_W{1'b0}} : (idx + IDX_W'(1))) : idx;
      disp_next    = (boundary && pending) ? shadow : disp;
      shadow_next  = load ? value : shadow;
      pending_next = load ? 1'b1 : (boundary ? 1'b0 : pending);

      disp_ext                   = {(4*MAX_DIGITS){1'b0}};
      disp_ext[4*N_DIGITS-1:0]   = disp_next;
      lz_full                    = lz_mask(disp_ext, N_DIGITS);
      lz_dark                    = (LZ_BLANK != 0) ? lz_full[N_DIGITS-1:0] : {N_DIGITS{1'b0}};
      lit                        = ~blank_mask & ~lz_dark;

      hex_next = 4'h0;
      en_hi    = {N_DIGITS{1'b0}};
      sel      = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         sel      = (idx_next == IDX_W'(i));
         hex_next = sel ? disp_next[4*i +: 4] : hex_next;
         en_hi[i] = sel & guard_done & lit[i];
      end
      dig_en_next = (AN_ACTIVE_LOW != 0) ? ~en_hi : en_hi;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= {IDX_W{1'b0}};
         shadow     <= {(4*N_DIGITS){1'b0}};
         disp       <= {(4*N_DIGITS){1'b0}};
         pending    <= 1'b0;
         frame_done <= 1'b0;
         hex        <= 4'h0;
         dig_en     <= EN_OFF;
      end else begin
         idx        <= idx_next;
         shadow     <= shadow_next;
         disp       <= disp_next;
         pending    <= pending_next;
         frame_done <= boundary;
         hex        <= hex_next;
         dig_en     <= dig_en_next;
      end
   end

endmodule
